// File: rtl/viterbi_pkg.sv
// Shared definitions for the framed convolutional encoder.
//   enc_state_e : frame FSM states (IDLE -> DATA -> TAIL -> IDLE)
//   K_MIN/K_MAX : legal constraint-length range
//   N_MIN/N_MAX : legal number of generator polynomials
//   parity()    : XOR-reduce of a tap-masked window, zero-extended to K_MAX
package viterbi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } enc_state_e;

  localparam int K_MIN = 3;
  localparam int K_MAX = 9;
  localparam int N_MIN = 2;
  localparam int N_MAX = 4;

  function automatic logic parity(input logic [K_MAX-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/viterbi_punct_mask.sv
// Puncture phase tracker for the framed convolutional encoder.
// Only instantiated when VITERBI_ENC_FRAME_PUNCT_EN is defined.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_step          : an output symbol is produced this cycle
//   i_frame_start   : first symbol of a new frame (forces phase 0)
//   o_keep[N-1:0]   : keep flags for the symbol produced this cycle
module viterbi_punct_mask
  import viterbi_pkg::*;
#(
  parameter int                                       p_num_polinom  = 2,
  parameter int                                       p_punct_period = 3,
  parameter logic [p_num_polinom*p_punct_period-1:0]  p_punct_mask   = 6'b011101
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_step,
  input  logic                     i_frame_start,
  output logic [p_num_polinom-1:0] o_keep
);

  localparam int PW = (p_punct_period > 1) ? $clog2(p_punct_period) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(p_punct_period - 1);

  logic [PW-1:0] phase_q, phase_d, phase_cur;

  always_comb begin
    // A new frame always starts at phase 0, whatever the previous frame left behind.
    phase_cur = i_frame_start ? '0 : phase_q;
    o_keep    = '0;
    for (int p = 0; p < p_punct_period; p++) begin
      if (phase_cur == PW'(p)) begin
        for (int n = 0; n < p_num_polinom; n++) begin
          o_keep[n] = p_punct_mask[n*p_punct_period + p];
        end
      end
    end
    phase_d = phase_q;
    if (i_step) begin
      phase_d = (phase_cur == PHASE_LAST) ? '0 : phase_cur + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/viterbi_enc_frame.sv
// Framed rate-1/N convolutional encoder with zero-tail termination.
// Each accepted bit yields one N-bit symbol one cycle later; after the bit
// flagged i_last, K-1 zero bits are flushed (input stalled) and the last of
// those symbols carries o_last. The state then reloads p_defoult_state.
// Optional feature macro: VITERBI_ENC_FRAME_PUNCT_EN adds per-symbol puncture
// keep flags on o_mask; without it o_mask is tied to all ones.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_data, i_valid, i_last : input bit stream, i_last marks final frame bit
//   o_ready                 : bit accepted when i_valid && o_ready
//   o_data[N-1:0], o_valid  : coded symbol, bit n from polynomial n
//   o_last                  : final tail symbol of the frame
//   o_mask[N-1:0]           : puncture keep flags for o_data
//   o_busy                  : frame in progress
module viterbi_enc_frame
  import viterbi_pkg::*;
#(
  parameter int                                         p_size_polinom  = 7,
  parameter int                                         p_num_polinom   = 2,
  parameter logic [p_num_polinom*p_size_polinom-1:0]    p_polinoms      = {7'b1101101, 7'b1001111},
  parameter logic [p_size_polinom-2:0]                  p_defoult_state = '0,
  parameter int                                         p_punct_period  = 3,
  parameter logic [p_num_polinom*p_punct_period-1:0]    p_punct_mask    = 6'b011101
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_data,
  input  logic                     i_valid,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic [p_num_polinom-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_last,
  output logic [p_num_polinom-1:0] o_mask,
  output logic                     o_busy
);

  localparam int K   = p_size_polinom;
  localparam int N   = p_num_polinom;
  localparam int TCW = $clog2(K);
  localparam logic [TCW-1:0] TAIL_LAST = TCW'(K - 2);

  if (K < K_MIN || K > K_MAX || N < N_MIN || N > N_MAX ||
      p_punct_period < 1 || p_punct_mask == '0) begin : g_bad_params
    $error("viterbi_enc_frame: illegal parameter set");
  end

  enc_state_e      state_q, state_d;
  logic [K-2:0]    shreg_q, shreg_d;
  logic [TCW-1:0]  tail_cnt_q, tail_cnt_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  logic            accept;
  logic            enc_step;
  logic            enc_bit;
  logic [K-1:0]    window;
  logic [N-1:0]    code;

  assign o_ready  = (state_q != ST_TAIL);
  assign o_busy   = (state_q != ST_IDLE);
  assign accept   = i_valid && o_ready;
  // In TAIL a zero is pushed every cycle regardless of the input handshake.
  assign enc_step = (state_q == ST_TAIL) || accept;
  assign enc_bit  = (state_q == ST_TAIL) ? 1'b0 : i_data;

  always_comb begin
    window = {enc_bit, shreg_q};
    code   = '0;
    for (int n = 0; n < N; n++) begin
      code[n] = parity(K_MAX'(window & p_polinoms[n*K +: K]));
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    tail_cnt_d = tail_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;

    if (enc_step) begin
      shreg_d = window[K-1:1];
      data_d  = code;
      valid_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          if (i_last) begin
            state_d    = ST_TAIL;
            tail_cnt_d = '0;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_TAIL: begin
        if (tail_cnt_q == TAIL_LAST) begin
          state_d    = ST_IDLE;
          tail_cnt_d = '0;
          shreg_d    = p_defoult_state;
          last_d     = 1'b1;
        end else begin
          tail_cnt_d = tail_cnt_q + TCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= p_defoult_state;
      tail_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      tail_cnt_q <= tail_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;

`ifdef VITERBI_ENC_FRAME_PUNCT_EN
  logic         frame_start;
  logic [N-1:0] keep;
  logic [N-1:0] mask_q, mask_d;

  assign frame_start = accept && (state_q == ST_IDLE);

  viterbi_punct_mask #(
    .p_num_polinom  (N),
    .p_punct_period (p_punct_period),
    .p_punct_mask   (p_punct_mask)
  ) u_punct_mask (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_step        (enc_step),
    .i_frame_start (frame_start),
    .o_keep        (keep)
  );

  // Keep flags are registered alongside the symbol they describe.
  always_comb begin
    mask_d = mask_q;
    if (enc_step) begin
      mask_d = keep;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign o_mask = mask_q;
`else
  assign o_mask = '1;
`endif

endmodule

// File: tb/tb_viterbi_enc_frame.sv
// Self-checking bench for viterbi_enc_frame (default parameters).
// Reference: direct convolution of the frame bits (plus K-1 zero tail) with
// the generator polynomials.
module tb_viterbi_enc_frame;

  localparam int K = 7;
  localparam int N = 2;
  localparam logic [K-1:0] POLY0 = 7'b1001111;
  localparam logic [K-1:0] POLY1 = 7'b1101101;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_data;
  logic         i_valid;
  logic         i_last;
  logic         o_ready;
  logic [N-1:0] o_data;
  logic         o_valid;
  logic         o_last;
  logic [N-1:0] o_mask;
  logic         o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic       fb      [0:63];
  logic [1:0] obs_sym [0:63];
  logic [1:0] ref_sym [0:63];

  viterbi_enc_frame dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_mask  (o_mask),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ubit(input int j, input int n);
    if (j < 0 || j >= n) return 1'b0;
    return fb[j];
  endfunction

  // Symbol j = sum over taps i of g[K-1-i] * u[j-i] (mod 2), zero initial state.
  function automatic logic [1:0] model_sym(input int j, input int n);
    logic [1:0]   r;
    logic [K-1:0] g0;
    logic [K-1:0] g1;
    r  = 2'b00;
    g0 = POLY0;
    g1 = POLY1;
    for (int i = 0; i < K; i++) begin
      r[0] = r[0] ^ (g0[K-1-i] & ubit(j - i, n));
      r[1] = r[1] ^ (g1[K-1-i] & ubit(j - i, n));
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_mask(input int idx);
`ifdef VITERBI_ENC_FRAME_PUNCT_EN
    logic [1:0] tab [0:2];
    tab[0] = 2'b11;
    tab[1] = 2'b10;
    tab[2] = 2'b01;
    return tab[idx % 3];
`else
    return 2'b11;
`endif
  endfunction

  task automatic check_sym(input int idx, input int n, input logic last, input logic busy);
    chk($sformatf("valid[%0d]", idx), o_valid, 1);
    chk($sformatf("data[%0d]", idx), o_data, model_sym(idx, n));
    chk($sformatf("last[%0d]", idx), o_last, last);
    chk($sformatf("busy[%0d]", idx), o_busy, busy);
    chk($sformatf("mask[%0d]", idx), o_mask, exp_mask(idx));
    obs_sym[idx] = o_data;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_mask"}, o_mask, 2'b11);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_ready"}, o_ready, 1);
  endtask

  // gap_mode: 0 none, 1 one idle cycle before every bit, 2 random idle cycles.
  task automatic run_frame(input int n, input int gap_mode, input bit hold_tail);
    int  idx;
    bit  gap;
    idx = 0;
    for (int i = 0; i < n; i++) begin
      gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 99) < 30);
      if (gap) begin
        i_valid = 1'b0;
        i_data  = 1'($urandom);
        i_last  = 1'($urandom);
        chk("ready_gap", o_ready, 1);
        tick();
        chk("gap_valid", o_valid, 0);
        chk("gap_last", o_last, 0);
        chk("gap_busy", o_busy, (i > 0) ? 1 : 0);
      end
      i_valid = 1'b1;
      i_data  = fb[i];
      i_last  = (i == n - 1);
      chk("ready_data", o_ready, 1);
      tick();
      check_sym(idx, n, 1'b0, 1'b1);
      idx++;
    end
    for (int j = 0; j < K - 1; j++) begin
      i_valid = hold_tail;
      i_data  = 1'($urandom);
      i_last  = 1'($urandom);
      chk($sformatf("ready_tail[%0d]", j), o_ready, 0);
      tick();
      check_sym(idx, n, (j == K - 2), (j != K - 2));
      idx++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("ready_after_tail", o_ready, 1);
    if (!hold_tail) begin
      tick();
      chk("idle_valid", o_valid, 0);
      chk("idle_last", o_last, 0);
      chk("idle_busy", o_busy, 0);
    end
  endtask

  task automatic check_impulse_table(input string tag);
    logic [6:0] d0;
    logic [6:0] d1;
    d0 = 7'b1111001;  // element j at bit j: 1,0,0,1,1,1,1
    d1 = 7'b1011011;  // element j at bit j: 1,1,0,1,1,0,1
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("%s_d0[%0d]", tag, j), obs_sym[j][0], d0[j]);
      chk($sformatf("%s_d1[%0d]", tag, j), obs_sym[j][1], d1[j]);
    end
  endtask

  initial begin
    logic [10:0] pat;
    int          n;

    // Reset asserted together with a valid last bit: reset must win.
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_data  = 1'b1;
    i_last  = 1'b1;
    tick();
    check_reset("rst0");
    tick();
    check_reset("rst1");
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    tick();
    chk("post_rst_valid", o_valid, 0);

    // Impulse frame.
    fb[0] = 1'b1;
    run_frame(1, 0, 1'b0);
    check_impulse_table("imp");

    // All-zero frame of 11 bits.
    for (int i = 0; i < 11; i++) fb[i] = 1'b0;
    run_frame(11, 0, 1'b0);

    // Known pattern with i_valid held through the tail, followed at once by
    // the same pattern gapless, then gapped; coded streams must agree.
    pat = 11'b11001111010;
    for (int i = 0; i < 11; i++) fb[i] = pat[i];
    run_frame(11, 0, 1'b1);
    run_frame(11, 0, 1'b0);
    for (int j = 0; j < 17; j++) ref_sym[j] = obs_sym[j];
    run_frame(11, 1, 1'b0);
    for (int j = 0; j < 17; j++) chk($sformatf("gapped_eq[%0d]", j), obs_sym[j], ref_sym[j]);

    // Reset after 5 bits of an 11-bit frame.
    for (int i = 0; i < 11; i++) fb[i] = 1'($urandom);
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data  = fb[i];
      i_last  = 1'b0;
      tick();
      check_sym(i, 11, 1'b0, 1'b1);
    end
    i_reset = 1'b1;
    i_data  = 1'($urandom);
    tick();
    check_reset("midrst");
    i_reset = 1'b0;
    i_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("midrst_valid[%0d]", c), o_valid, 0);
      chk($sformatf("midrst_last[%0d]", c), o_last, 0);
    end
    fb[0] = 1'b1;
    run_frame(1, 0, 1'b0);
    check_impulse_table("imp2");

    // Random frames.
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) fb[i] = 1'($urandom);
      run_frame(n, $urandom_range(0, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_enc_frame.md
VITERBI_ENC_FRAME -- requirements
Module: viterbi_enc_frame

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  p_size_polinom, 7, constraint length K, legal 3..9
  p_num_polinom, 2, number of generator polynomials N (rate 1/N), legal 2..4
  p_polinoms, {7'b1101101,7'b1001111}, N*K bits; polynomial n = p_polinoms[n*K +: K]
  p_defoult_state, 0, K-1 bit encoder state loaded at reset and frame end
  p_punct_period, 3, puncture period P (used only with macro)
  p_punct_mask, 6'b011101, N*P bits; keep bit for output n at phase k = p_punct_mask[n*P+k]
REQ-002 Ports SHALL be (name direction width meaning):
  i_clk  in  1  single clock, all logic on rising edge
  i_reset  in  1  synchronous, active-high reset
  i_data  in  1  information bit
  i_valid  in  1  i_data valid
  i_last  in  1  qualifies last bit of frame when i_valid
  o_ready  out  1  block accepts a bit this cycle
  o_data  out  N  coded bits, bit n from polynomial n
  o_valid  out  1  o_data valid
  o_last  out  1  last coded symbol of frame (final tail symbol)
  o_mask  out  N  per-bit puncture keep flags for o_data
  o_busy  out  1  frame in progress (DATA or TAIL)

Function
REQ-003 Accept SHALL occur when i_valid && o_ready; i_last ignored when i_valid=0.
REQ-004 Encoder window SHALL be w = {bit, s}, s the K-1 bit state; o_data[n] = XOR-reduce(w & poly n); next s = w[K-1:1].
REQ-005 Latency SHALL be one cycle: o_data/o_valid registered on the edge after accept or tail step.
REQ-006 FSM states SHALL be IDLE, DATA, TAIL.
REQ-007 IDLE: o_ready=1, o_busy=0; accept without i_last -> DATA; accept with i_last -> TAIL.
REQ-008 DATA: o_ready=1, o_busy=1; accept with i_last -> TAIL; gaps in i_valid hold state, o_valid=0.
REQ-009 TAIL: o_ready=0, o_busy=1; exactly K-1 zero bits SHALL be encoded, one per cycle, each producing o_valid=1; input ignored.
REQ-010 Tail counter width SHALL be $clog2(K); on final tail step -> IDLE, s reloads p_defoult_state, o_last=1 with that symbol.
REQ-011 A frame of N_in bits SHALL yield exactly N_in+K-1 output symbols, o_last only on the last.
REQ-012 o_last SHALL be 0 whenever o_valid=0.

Reset
REQ-013 On i_reset=1 at an edge: state IDLE, s=p_defoult_state, tail and puncture counters 0, o_valid=0, o_last=0, o_data=0, o_mask=all ones, o_busy=0.
REQ-014 Reset mid-frame SHALL abort the frame with no o_last and no further outputs; o_ready=1 the cycle after reset.
REQ-015 i_reset SHALL take priority over a simultaneous accept.

Configuration
REQ-016 Macro VITERBI_ENC_FRAME_PUNCT_EN SHALL compile in puncture marking: phase counter 0..P-1 advancing per output symbol (data and tail), wrapping P-1 -> 0, cleared at reset and at frame start; o_mask[n] = keep bit for current phase.
REQ-017 Without the macro, o_mask SHALL be constant all ones and no phase counter exists; o_data unaffected in both cases.

Structure
REQ-018 Package viterbi_pkg SHALL hold the FSM state enum, K/N limit constants, and the parity-reduce function.
REQ-019 Puncture phase counter and mask lookup SHALL be sub-module viterbi_punct_mask, instantiated only under the macro.

Verification
REQ-020 Impulse: 1-bit frame i_data=1, i_last=1, defaults -> 7 symbols, o_data[0] = 1,0,0,1,1,1,1, o_data[1] = 1,1,0,1,1,0,1, o_last on 7th.
REQ-021 Zero frame: 11 bits all 0 -> 17 symbols all 2'b00, o_ready low exactly 6 cycles, o_last on 17th.
REQ-022 Input during TAIL: hold i_valid=1 through tail -> bits not accepted, next frame starts only after o_last cycle; output matches software model of 11001111010 (LSB first).
REQ-023 Gapped input: i_valid toggling 1,0 -> o_valid follows with 1-cycle lag, coded sequence identical to gapless run.
REQ-024 Reset after 5 bits of an 11-bit frame -> o_valid=0 next cycle, no o_last, following impulse frame reproduces REQ-020.
REQ-025 With VITERBI_ENC_FRAME_PUNCT_EN, defaults: o_mask = 2'b11, 2'b10, 2'b01 repeating from frame start across tail; without macro o_mask = 2'b11 always.
